// File: rtl/inst_fetch_bridge_if.sv
// Instruction bus between the fetch bridge (master) and the memory side (slave).
// A single-outstanding request/grant/response protocol:
//   bus_req/bus_addr held until bus_gnt, then exactly one bus_rvalid beat.
interface inst_fetch_bridge_if;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req,
    output bus_addr,
    input  bus_gnt,
    input  bus_rvalid,
    input  bus_rdata
  );

  modport slave (
    input  bus_req,
    input  bus_addr,
    output bus_gnt,
    output bus_rvalid,
    output bus_rdata
  );
endinterface

// File: rtl/inst_fetch_bridge.sv
// Instruction-fetch responder between the PC register and the instruction bus.
// Translates kseg0/kseg1 addresses, runs one bus transaction at a time, keeps
// the last fetched word in a hold buffer tagged with its PC, and raises
// stallreq until the word for the current PC is available.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no transaction; start one when the current pc is not held
// REQ   | bus_req asserted with a stable bus_addr, waiting for bus_gnt
// WAIT  | granted, waiting for bus_rvalid; tcnt counts toward timeout
// FAULT | bus timed out; excp_ibe asserted until a flush
module inst_fetch_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] NOP_INST       = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                pc,
  input  logic                       ce,
  input  logic                       flush,
  inst_fetch_bridge_if.master        bus,
  output logic [31:0]                inst_o,
  output logic                       inst_valid,
  output logic                       stallreq,
  output logic                       excp_adel,
  output logic                       excp_ibe
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    FAULT = 2'd3
  } state_t;

  // Last WAIT count value before the timeout fires.
  localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic        bus_req_r;
  logic [31:0] bus_addr_r;
  logic [31:0] req_pc;
  logic        discard;
  logic [7:0]  tcnt;
  logic        excp_ibe_r;
  logic        held_valid;
  logic [31:0] held_pc;
  logic [31:0] held_inst;

  // kseg0 (100) and kseg1 (101) strip the top three bits; other segments pass.
  function automatic logic [31:0] map_addr(input logic [31:0] va);
    if (va[31:29] == 3'b100 || va[31:29] == 3'b101) begin
      return {3'b000, va[28:0]};
    end
    return va;
  endfunction

  assign excp_adel  = ce & (pc[1:0] != 2'b00);
  assign inst_valid = ce & held_valid & (held_pc == pc);
  assign inst_o     = inst_valid ? held_inst : NOP_INST;
  assign stallreq   = ce & ~inst_valid & ~excp_adel & ~excp_ibe_r;
  assign excp_ibe   = excp_ibe_r;

  assign bus.bus_req  = bus_req_r;
  assign bus.bus_addr = bus_addr_r;

  // Fetch sequencer, bus request registers, timeout counter and hold buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bus_req_r  <= 1'b0;
      bus_addr_r <= 32'h0;
      req_pc     <= 32'h0;
      discard    <= 1'b0;
      tcnt       <= 8'h0;
      excp_ibe_r <= 1'b0;
      held_valid <= 1'b0;
      held_pc    <= 32'h0;
      held_inst  <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (ce && !inst_valid && !excp_adel && !flush) begin
            state      <= REQ;
            bus_req_r  <= 1'b1;
            bus_addr_r <= map_addr(pc);
            req_pc     <= pc;
            discard    <= 1'b0;
          end
        end
        REQ: begin
          // The request stays up until granted, even across a flush; the
          // flush only marks the eventual response as stale.
          if (flush) begin
            discard <= 1'b1;
          end
          if (bus.bus_gnt) begin
            state     <= WAIT;
            bus_req_r <= 1'b0;
            tcnt      <= 8'h0;
          end
        end
        WAIT: begin
          tcnt <= tcnt + 8'h1;
          if (flush) begin
            discard <= 1'b1;
          end
          if (bus.bus_rvalid) begin
            if (!discard && !flush) begin
              held_valid <= 1'b1;
              held_pc    <= req_pc;
              held_inst  <= bus.bus_rdata;
            end
            state <= IDLE;
          end else if (tcnt == TCNT_LAST) begin
            state      <= FAULT;
            excp_ibe_r <= 1'b1;
          end
        end
        FAULT: begin
          bus_req_r <= 1'b0;
          if (flush) begin
            state      <= IDLE;
            excp_ibe_r <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          bus_req_r <= 1'b0;
        end
      endcase

      // A redirect invalidates the held word regardless of state; the WAIT
      // capture above is already suppressed when flush is high.
      if (flush) begin
        held_valid <= 1'b0;
      end
    end
  end

endmodule
